// File: rtl/adc_frame_sched.sv
// Acquisition controller for the multi-channel ADC source: gates the source,
// snapshots every channel on trigger and streams header/data/checksum frames.
module adc_frame_sched #(
    parameter int unsigned CH_NUM = 24,
    parameter logic [15:0] SYNC   = 16'hA55A
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    output logic                     adc_en,
    input  logic                     trigger,
    input  logic [CH_NUM*32-1:0]     adc_data,
    output logic [31:0]              m_data,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic                     busy,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              overrun_cnt
);

    localparam int unsigned IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA, TAIL} state_t;

    state_t         state, state_nxt;
    logic           run;
    logic [31:0]    snap [CH_NUM];
    logic [IW-1:0]  idx, idx_nxt;
    logic [31:0]    csum, csum_nxt;
    logic [31:0]    data_nxt;
    logic [15:0]    frame_nxt, ovr_nxt;
    logic           hs, capture, drop;

    // Run flag: stop has priority over start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else if (stop) begin
            run <= 1'b0;
        end else if (start) begin
            run <= 1'b1;
        end
    end

    // Next-state, counters, and the word to present after this edge
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        csum_nxt  = csum;
        frame_nxt = frame_cnt;
        ovr_nxt   = overrun_cnt;
        capture   = 1'b0;
        data_nxt  = 32'd0;
        hs        = m_valid & m_ready;
        drop      = trigger & run & (state != IDLE);

        if (drop && (overrun_cnt != 16'hFFFF)) begin
            ovr_nxt = overrun_cnt + 16'd1;
        end

        case (state)
            IDLE: begin
                if (trigger && run) begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    csum_nxt  = 32'd0;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (hs) state_nxt = DATA;
            end
            DATA: begin
                if (hs) begin
                    csum_nxt = csum ^ snap[idx];
                    if (idx == IW'(CH_NUM - 1)) begin
                        state_nxt = TAIL;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            TAIL: begin
                if (hs) begin
                    frame_nxt = frame_cnt + 16'd1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Presented word follows the upcoming state so a stall simply re-registers it
        case (state_nxt)
            HDR:     data_nxt = {SYNC, frame_cnt};
            DATA:    data_nxt = snap[idx_nxt];
            TAIL:    data_nxt = csum_nxt;
            default: data_nxt = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            csum        <= 32'd0;
            frame_cnt   <= 16'd0;
            overrun_cnt <= 16'd0;
            m_data      <= 32'd0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            csum        <= csum_nxt;
            frame_cnt   <= frame_nxt;
            overrun_cnt <= ovr_nxt;
            m_data      <= data_nxt;
            m_valid     <= (state_nxt != IDLE);
            m_last      <= (state_nxt == TAIL);
            busy        <= (state_nxt != IDLE);
        end
    end

    // Snapshot is only loaded when a frame is actually started
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < CH_NUM; k++) snap[k] <= 32'd0;
        end else if (capture) begin
            for (int unsigned k = 0; k < CH_NUM; k++) snap[k] <= adc_data[32*k +: 32];
        end
    end

    assign adc_en = run;

endmodule
